mem_rr_arbiter: RTL and testbench

//  - Round-robin, N-requester arbiter for the core's single native memory bus (valid/ready/addr/rdata/wdata/wstrb).
//  - Shares one external memory port between icache refill, execute load/store and future masters (debug, DMA).
//  - Replaces the fixed two-port sharing. Grant held for a whole transaction; fairness guaranteed by a rotating pointer.

---
 rtl/mem_rr_arbiter_if.sv | 28 ++
 rtl/mem_rr_arbiter.sv | 68 ++++++
 tb/tb_mem_rr_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester and memory bus bundle for mem_rr_arbiter
// master: requester/memory side, drives requests and memory responses
// slave: arbiter side, drives completion strobes and the memory request
// Per-port fields are packed with port p at [32p+31:32p] for addr/wdata and [4p+3:4p] for wstrb
interface mem_rr_arbiter_if #(
  parameter int NUM_PORTS = 3
);
  logic [NUM_PORTS-1:0]    req_valid;
  logic [NUM_PORTS-1:0]    req_ready;
  logic [NUM_PORTS*32-1:0] req_addr;
  logic [NUM_PORTS*32-1:0] req_wdata;
  logic [NUM_PORTS*4-1:0]  req_wstrb;
  logic [31:0]             req_rdata;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_rdata;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_wstrb;
  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    input  req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    output req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin N-port arbiter sharing one native memory bus
// Ports: clk, rst (sync, active-high), bus (mem_rr_arbiter_if.slave: requests in, memory out),
//   grant_id (registered index of current/last grant), busy (transaction in flight),
//   timeout (sticky watchdog fault).
// Define MEM_TIMEOUT_EN to enable the BUSY watchdog (TIMEOUT_CYCLES); otherwise timeout is tied 0.
module mem_rr_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDW = $clog2(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  mem_rr_arbiter_if.slave  bus,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [IDW-1:0] last, pick;
  logic fire, done;
  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_rr_arbiter: unsupported parameters");
  end
  assign busy = state == BUSY;
  assign done = busy && (bus.mem_ready || fire);
  always_comb begin
    pick = '0;
    for (int i = NUM_PORTS; i >= 1; i--)
      pick = bus.req_valid[(int'(last) + i) % NUM_PORTS] ? IDW'((int'(last) + i) % NUM_PORTS) : pick;
  end
  always_comb begin
    state_n = busy ? (done ? IDLE : BUSY) : (|bus.req_valid ? BUSY : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      last <= IDW'(NUM_PORTS - 1);
    end else begin
      state <= state_n;
      if (!busy && |bus.req_valid) grant_id <= pick;
      if (done) last <= grant_id;
    end
  end
  assign bus.mem_valid = busy;
  assign bus.mem_addr  = busy ? bus.req_addr[32*int'(grant_id) +: 32] : '0;
  assign bus.mem_wdata = busy ? bus.req_wdata[32*int'(grant_id) +: 32] : '0;
  assign bus.mem_wstrb = busy ? bus.req_wstrb[4*int'(grant_id) +: 4] : '0;
  assign bus.req_ready = (busy && bus.mem_ready) ? NUM_PORTS'(1) << grant_id : '0;
  assign bus.req_rdata = bus.mem_rdata;
`ifdef MEM_TIMEOUT_EN
  logic [31:0] wait_cnt;
  assign fire = busy && !bus.mem_ready && wait_cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      wait_cnt <= (busy && !bus.mem_ready) ? wait_cnt + 32'd1 : '0;
      if (fire) timeout <= 1'b1;
    end
  end
`else
  assign fire = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed self-checking bench for mem_rr_arbiter
module tb_mem_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] grant_id;
  logic busy, timeout;
  int errors = 0;
  int checks = 0;
  mem_rr_arbiter_if #(.NUM_PORTS(3)) bus ();
  mem_rr_arbiter #(.NUM_PORTS(3), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    step();
    step();
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    bus.req_valid = 3'b001;
    bus.req_addr[31:0] = 32'h0000_0100;
    step();
    chk("rd_mem_valid", bus.mem_valid, 1);
    chk("rd_mem_addr", bus.mem_addr, 32'h100);
    chk("rd_wstrb", bus.mem_wstrb, 0);
    chk("rd_grant", grant_id, 0);
    chk("rd_no_ready0", bus.req_ready, 0);
    step();
    chk("rd_no_ready1", bus.req_ready, 0);
    step();
    chk("rd_no_ready2", bus.req_ready, 0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_ready", bus.req_ready, 3'b001);
    chk("rd_rdata", bus.req_rdata, 32'hDEAD_BEEF);
    step();
    chk("rd_done_valid", bus.mem_valid, 0);
    chk("rd_done_ready", bus.req_ready, 0);
    bus.req_valid = '0;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid = 3'b111;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rr_grant%0d", k), grant_id, k % 3);
      chk($sformatf("rr_ready%0d", k), bus.req_ready, 3'b001 << (k % 3));
      step();
      chk($sformatf("rr_bubble%0d", k), busy, 0);
    end
    bus.req_valid = '0;
    bus.mem_ready = 1'b0;
    bus.req_addr[63:32] = 32'h20;
    bus.req_wdata[63:32] = 32'h1234;
    bus.req_wstrb[7:4] = 4'b0011;
    bus.req_valid = 3'b010;
    step();
    chk("wr_grant", grant_id, 1);
    chk("wr_addr", bus.mem_addr, 32'h20);
    chk("wr_wdata", bus.mem_wdata, 32'h1234);
    chk("wr_wstrb", bus.mem_wstrb, 4'b0011);
    bus.mem_ready = 1'b1;
    #1;
    chk("wr_ready", bus.req_ready, 3'b010);
    step();
    bus.req_valid = 3'b100;
    step();
    chk("p2_grant", grant_id, 2);
    chk("p2_ready", bus.req_ready, 3'b100);
    step();
    bus.mem_ready = 1'b0;
    bus.req_valid = 3'b101;
    step();
    chk("wrap_grant", grant_id, 0);
    chk("wrap_addr", bus.mem_addr, 32'h100);
    bus.mem_ready = 1'b1;
    #1;
    chk("wrap_ready", bus.req_ready, 3'b001);
    step();
    bus.req_valid = 3'b100;
    step();
    chk("wrap_next_grant", grant_id, 2);
    step();
    bus.req_valid = '0;
    bus.mem_ready = 1'b0;
    bus.req_valid = 3'b010;
    step();
    chk("mid_busy", busy, 1);
    chk("mid_grant", grant_id, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", bus.mem_valid, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    bus.req_valid = 3'b011;
    step();
    chk("post_rst_grant", grant_id, 0);
    bus.mem_ready = 1'b1;
    step();
    bus.req_valid = '0;
    step();
    chk("idle_ready_ignored", bus.req_ready, 0);
    chk("idle_ready_busy", busy, 0);
    step();
    chk("idle_stay", bus.mem_valid, 0);
    bus.mem_ready = 1'b0;
`ifdef MEM_TIMEOUT_EN
    bus.req_valid = 3'b001;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("to_busy%0d", k), busy, 1);
      chk($sformatf("to_clear%0d", k), timeout, 0);
      chk($sformatf("to_noready%0d", k), bus.req_ready, 0);
    end
    step();
    chk("to_fired", timeout, 1);
    chk("to_valid", bus.mem_valid, 0);
    bus.req_valid = '0;
    step();
    step();
    chk("to_sticky", timeout, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("to_rst", timeout, 0);
`else
    bus.req_valid = 3'b001;
    for (int k = 0; k < 20; k++) step();
    chk("no_to_busy", busy, 1);
    chk("no_to_flag", timeout, 0);
    bus.mem_ready = 1'b1;
    #1;
    chk("no_to_ready", bus.req_ready, 3'b001);
    step();
    bus.req_valid = '0;
    bus.mem_ready = 1'b0;
    step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
